// File: rtl/reg_scoreboard_if.sv
// Issue / writeback / status bundle for the decode-stage register scoreboard.
interface reg_scoreboard_if #(
    parameter int unsigned NUM_REGS = 32
);
    // Issue side (driven by decode)
    logic                issue_valid;
    logic                issue_ready;
    logic [4:0]          issue_src_a;
    logic [4:0]          issue_src_b;
    logic                issue_use_a;
    logic                issue_use_b;
    logic                issue_wr;
    logic [4:0]          issue_dest;

    // Writeback side (same nets as the register file load/dest)
    logic                wb_load;
    logic [4:0]          wb_dest;

    // Pipeline squash
    logic                flush;

    // Status
    logic [NUM_REGS-1:0] busy_vec;
    logic                err_underflow;

    // Decode / writeback / flush control as seen by the pipeline
    modport master (
        output issue_valid, issue_src_a, issue_src_b, issue_use_a, issue_use_b,
               issue_wr, issue_dest, wb_load, wb_dest, flush,
        input  issue_ready, busy_vec, err_underflow
    );

    // Scoreboard side
    modport slave (
        input  issue_valid, issue_src_a, issue_src_b, issue_use_a, issue_use_b,
               issue_wr, issue_dest, wb_load, wb_dest, flush,
        output issue_ready, busy_vec, err_underflow
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register pending-write counters between
// issue and register-file writeback, with a same-cycle writeback bypass.
module reg_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned CNT_W    = 2
) (
    input  logic            clk,
    input  logic            rst,
    reg_scoreboard_if.slave bus
);
    localparam int unsigned      IDX_W   = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Entry 0 exists only to keep indexing simple; it is held at zero.
    logic [CNT_W-1:0]    r_count     [NUM_REGS];
    logic [CNT_W-1:0]    w_count_nxt [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy_vec;
    logic                r_err_underflow;

    logic [CNT_W-1:0]    w_cnt_a;
    logic [CNT_W-1:0]    w_cnt_b;
    logic [CNT_W-1:0]    w_cnt_d;
    logic [CNT_W-1:0]    w_cnt_wb;

    logic                w_byp_a;
    logic                w_byp_b;
    logic                w_hz_a;
    logic                w_hz_b;
    logic                w_hz_d;
    logic                w_ready;
    logic                w_accept;
    logic                w_inc_wb;
    logic                w_underflow;

    logic [NUM_REGS-1:0] w_inc_vec;
    logic [NUM_REGS-1:0] w_dec_vec;

    // Count lookup for each index the hazard logic cares about; out-of-range
    // and x0 indices read as zero.
    always_comb begin
        w_cnt_a  = '0;
        w_cnt_b  = '0;
        w_cnt_d  = '0;
        w_cnt_wb = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (bus.issue_src_a == IDX_W'(i)) w_cnt_a  = r_count[i];
            if (bus.issue_src_b == IDX_W'(i)) w_cnt_b  = r_count[i];
            if (bus.issue_dest  == IDX_W'(i)) w_cnt_d  = r_count[i];
            if (bus.wb_dest     == IDX_W'(i)) w_cnt_wb = r_count[i];
        end
    end

    // Source/destination hazards and the issue handshake.
    always_comb begin
        // Final pending write landing this cycle is forwarded by the register file.
        w_byp_a  = bus.wb_load && (bus.wb_dest == bus.issue_src_a) && (w_cnt_a == CNT_ONE);
        w_byp_b  = bus.wb_load && (bus.wb_dest == bus.issue_src_b) && (w_cnt_b == CNT_ONE);

        w_hz_a   = bus.issue_use_a && (bus.issue_src_a != '0) && (w_cnt_a != '0) && !w_byp_a;
        w_hz_b   = bus.issue_use_b && (bus.issue_src_b != '0) && (w_cnt_b != '0) && !w_byp_b;

        // A saturated counter may still accept a write if one retires this cycle.
        w_hz_d   = bus.issue_wr && (bus.issue_dest != '0) && (w_cnt_d == CNT_MAX)
                   && !(bus.wb_load && (bus.wb_dest == bus.issue_dest));

        w_ready  = !bus.flush && !w_hz_a && !w_hz_b && !w_hz_d;
        w_accept = bus.issue_valid && w_ready;

        // Writeback to a register that gets its first pending write this same cycle.
        w_inc_wb = w_accept && bus.issue_wr && (bus.issue_dest == bus.wb_dest);

        w_underflow = bus.wb_load && (bus.wb_dest != '0) && (w_cnt_wb == '0)
                      && !w_inc_wb && !bus.flush;
    end

    // Per-register increment/decrement requests and next counter values.
    always_comb begin
        w_inc_vec      = '0;
        w_dec_vec      = '0;
        w_count_nxt[0] = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_inc_vec[i] = w_accept && bus.issue_wr && (bus.issue_dest == IDX_W'(i));
            w_dec_vec[i] = bus.wb_load && (bus.wb_dest == IDX_W'(i)) && (r_count[i] != '0);

            w_count_nxt[i] = r_count[i];
            if (bus.flush) begin
                w_count_nxt[i] = '0;
            end else if (w_inc_vec[i] && !w_dec_vec[i]) begin
                w_count_nxt[i] = r_count[i] + CNT_ONE;
            end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
                w_count_nxt[i] = r_count[i] - CNT_ONE;
            end
        end
    end

    // Counter, busy vector and sticky underflow state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_count[i] <= '0;
            end
            r_busy_vec      <= '0;
            r_err_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_count[i]    <= w_count_nxt[i];
                r_busy_vec[i] <= (w_count_nxt[i] != '0);
            end
            if (w_underflow) begin
                r_err_underflow <= 1'b1;
            end
        end
    end

    assign bus.issue_ready   = w_ready;
    assign bus.busy_vec      = r_busy_vec;
    assign bus.err_underflow = r_err_underflow;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: reset, RAW stall/bypass, simultaneous
// issue+writeback, saturation, x0, flush, underflow and mid-run reset.
module tb_reg_scoreboard;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned CNT_W    = 2;

    logic clk = 1'b0;
    logic rst;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    reg_scoreboard_if #(.NUM_REGS(NUM_REGS)) sb ();

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sb.issue_valid = 1'b0;
        sb.issue_src_a = 5'd0;
        sb.issue_src_b = 5'd0;
        sb.issue_use_a = 1'b0;
        sb.issue_use_b = 1'b0;
        sb.issue_wr    = 1'b0;
        sb.issue_dest  = 5'd0;
        sb.wb_load     = 1'b0;
        sb.wb_dest     = 5'd0;
        sb.flush       = 1'b0;
    endtask

    task automatic rand_inputs();
        sb.issue_valid = 1'($urandom);
        sb.issue_src_a = 5'($urandom);
        sb.issue_src_b = 5'($urandom);
        sb.issue_use_a = 1'($urandom);
        sb.issue_use_b = 1'($urandom);
        sb.issue_wr    = 1'($urandom);
        sb.issue_dest  = 5'($urandom);
        sb.wb_load     = 1'($urandom);
        sb.wb_dest     = 5'($urandom);
        sb.flush       = 1'($urandom);
    endtask

    task automatic issue_wr(input logic [4:0] d);
        sb.issue_valid = 1'b1;
        sb.issue_wr    = 1'b1;
        sb.issue_dest  = d;
    endtask

    task automatic wb(input logic [4:0] d);
        sb.wb_load = 1'b1;
        sb.wb_dest = d;
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after changing inputs.
    task automatic settle();
        #1;
    endtask

    initial begin
        // Reset for two cycles with random inputs
        rst = 1'b1;
        rand_inputs();
        tick();
        rand_inputs();
        tick();
        rst = 1'b0;
        idle();
        settle();
        chk("rst_busy",  32'(sb.busy_vec),      32'h0);
        chk("rst_err",   32'(sb.err_underflow), 32'h0);
        chk("rst_ready", 32'(sb.issue_ready),   32'h1);

        // RAW stall on x5, released by the writeback bypass
        idle(); issue_wr(5'd5); settle();
        chk("raw_t0_ready", 32'(sb.issue_ready), 32'h1);
        tick();
        chk("raw_t1_busy5", 32'(sb.busy_vec), 32'h0000_0020);
        idle(); sb.issue_valid = 1'b1; sb.issue_use_a = 1'b1; sb.issue_src_a = 5'd5; settle();
        chk("raw_t1_stall", 32'(sb.issue_ready), 32'h0);
        tick();
        settle();
        chk("raw_t2_stall", 32'(sb.issue_ready), 32'h0);
        tick();
        wb(5'd5); settle();
        chk("raw_t3_bypass", 32'(sb.issue_ready), 32'h1);
        tick();
        idle(); settle();
        chk("raw_t4_busy", 32'(sb.busy_vec), 32'h0);

        // Source B hazard on x20, gated by use_b
        issue_wr(5'd20); tick();
        idle(); sb.issue_valid = 1'b1; sb.issue_use_b = 1'b1; sb.issue_src_b = 5'd20; settle();
        chk("hzb_stall", 32'(sb.issue_ready), 32'h0);
        sb.issue_use_b = 1'b0; settle();
        chk("hzb_unused", 32'(sb.issue_ready), 32'h1);
        idle(); wb(5'd20); tick();
        idle(); settle();
        chk("hzb_drain", 32'(sb.busy_vec), 32'h0);

        // Simultaneous issue and writeback to x7 while count is 1
        issue_wr(5'd7); tick();
        idle(); issue_wr(5'd7); wb(5'd7); settle();
        chk("sim_ready", 32'(sb.issue_ready), 32'h1);
        tick();
        idle(); settle();
        chk("sim_busy7", 32'(sb.busy_vec), 32'h0000_0080);
        issue_wr(5'd7); tick();                       // count[7] = 2
        idle(); sb.issue_valid = 1'b1; sb.issue_use_a = 1'b1; sb.issue_src_a = 5'd7; wb(5'd7); settle();
        chk("sim_no_bypass_cnt2", 32'(sb.issue_ready), 32'h0);
        tick();                                       // count[7] = 1
        settle();
        chk("sim_bypass_cnt1", 32'(sb.issue_ready), 32'h1);
        tick();                                       // count[7] = 0
        idle(); settle();
        chk("sim_drain", 32'(sb.busy_vec),      32'h0);
        chk("sim_no_uf", 32'(sb.err_underflow), 32'h0);

        // Saturation of x9 at CNT_W=2
        for (int k = 0; k < 3; k++) begin
            idle(); issue_wr(5'd9); settle();
            chk($sformatf("sat_issue%0d", k), 32'(sb.issue_ready), 32'h1);
            tick();
        end
        idle(); issue_wr(5'd9); settle();
        chk("sat_busy9", 32'(sb.busy_vec),    32'h0000_0200);
        chk("sat_stall", 32'(sb.issue_ready), 32'h0);
        tick();
        settle();
        chk("sat_stall_hold", 32'(sb.issue_ready), 32'h0);
        wb(5'd9); settle();
        chk("sat_wb_ready", 32'(sb.issue_ready), 32'h1);
        tick();
        sb.wb_load = 1'b0; settle();
        chk("sat_still_full", 32'(sb.issue_ready), 32'h0);
        idle(); wb(5'd9); tick(); tick();
        idle(); settle();
        chk("sat_one_left", 32'(sb.busy_vec), 32'h0000_0200);
        wb(5'd9); tick();
        idle(); settle();
        chk("sat_drain", 32'(sb.busy_vec),      32'h0);
        chk("sat_no_uf", 32'(sb.err_underflow), 32'h0);

        // x0 as destination and source
        idle(); issue_wr(5'd0);
        sb.issue_use_a = 1'b1; sb.issue_use_b = 1'b1; settle();
        chk("x0_ready", 32'(sb.issue_ready), 32'h1);
        tick(); tick();
        idle(); settle();
        chk("x0_busy", 32'(sb.busy_vec), 32'h0);

        // Flush with x1..x4 pending and a concurrent issue
        for (int r = 1; r <= 4; r++) begin
            idle(); issue_wr(5'(r)); tick();
        end
        idle(); settle();
        chk("flush_pre_busy", 32'(sb.busy_vec), 32'h0000_001E);
        issue_wr(5'd5); sb.issue_use_a = 1'b1; sb.issue_src_a = 5'd1; sb.flush = 1'b1; settle();
        chk("flush_ready", 32'(sb.issue_ready), 32'h0);
        tick();
        idle(); settle();
        chk("flush_busy", 32'(sb.busy_vec), 32'h0);
        sb.issue_valid = 1'b1; sb.issue_use_a = 1'b1; sb.issue_src_a = 5'd1; settle();
        chk("flush_after_ready", 32'(sb.issue_ready), 32'h1);
        idle(); sb.flush = 1'b1; wb(5'd13); tick();
        idle(); settle();
        chk("flush_suppress_uf", 32'(sb.err_underflow), 32'h0);

        // Underflow on x12
        issue_wr(5'd12); wb(5'd12); tick();           // inc wins, no underflow
        idle(); settle();
        chk("uf_inc_wb_err",  32'(sb.err_underflow), 32'h0);
        chk("uf_inc_wb_busy", 32'(sb.busy_vec),      32'h0000_1000);
        wb(5'd12); tick();
        idle(); settle();
        chk("uf_legal_wb_err", 32'(sb.err_underflow), 32'h0);
        wb(5'd12); tick();
        idle(); settle();
        chk("uf_set",  32'(sb.err_underflow), 32'h1);
        chk("uf_busy", 32'(sb.busy_vec),      32'h0);
        tick(); tick(); tick();
        sb.issue_valid = 1'b1; sb.issue_use_a = 1'b1; sb.issue_src_a = 5'd12; settle();
        chk("uf_hold",  32'(sb.err_underflow), 32'h1);
        chk("uf_ready", 32'(sb.issue_ready),   32'h1);

        // Reset mid-operation wins over a concurrent issue
        idle(); issue_wr(5'd3); tick();
        idle(); settle();
        chk("mid_busy3", 32'(sb.busy_vec), 32'h0000_0008);
        rst = 1'b1; issue_wr(5'd4); wb(5'd3); tick();
        rst = 1'b0; idle(); settle();
        chk("mid_rst_busy",  32'(sb.busy_vec),      32'h0);
        chk("mid_rst_err",   32'(sb.err_underflow), 32'h0);
        chk("mid_rst_ready", 32'(sb.issue_ready),   32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-hazard scoreboard for the decode stage of the pipelined RV32I core. Tracks outstanding writes to each architectural register between decode/issue and the register-file write port, and stalls issue while a source operand or the destination counter is not safe. Clears pending writes from the same writeback signals that drive the register file's `load`/`dest`. Its readiness rules match the register file's same-cycle write-through behaviour.

## Interface
- `NUM_REGS`, default 32: architectural register count. Register 0 is hardwired zero.
- `CNT_W`, default 2: width of each per-register pending-write counter. Maximum is 2^CNT_W−1.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `issue_valid` in 1: decode presents an instruction.
- `issue_ready` out 1: the instruction may issue this cycle.
- `issue_src_a`, `issue_src_b` in 5: source register indices.
- `issue_use_a`, `issue_use_b` in 1: the corresponding source is actually read.
- `issue_wr` in 1: the instruction writes a destination.
- `issue_dest` in 5: destination index.
- `wb_load` in 1: the writeback stage writes the register file this cycle. Same signal as the register file `load`.
- `wb_dest` in 5: writeback destination. Same signal as the register file `dest`.
- `flush` in 1: pipeline squash. All in-flight writes are discarded.
- `busy_vec` out NUM_REGS: bit i = (count[i] != 0). Bit 0 is always 0.
- `err_underflow` out 1: sticky flag, set by a writeback to a register whose count is 0.

## Operation
- State:
  - `count[i]`, CNT_W bits, for i = 1..NUM_REGS−1. `count[0]` does not exist and reads as 0.
  - `err_underflow` register.
- Source hazard. `hz_a = issue_use_a && src_a != 0 && count[src_a] != 0 && !byp_a`.
  - `byp_a = wb_load && wb_dest == src_a && count[src_a] == 1`. This is the final pending write landing now, which the register file forwards.
  - `hz_b` is identical with b.
- Destination hazard. `hz_d = issue_wr && issue_dest != 0 && count[issue_dest] == MAX && !(wb_load && wb_dest == issue_dest)`.
- `issue_ready = !flush && !hz_a && !hz_b && !hz_d`. This is combinational and independent of `issue_valid`.
- Accept occurs when `issue_valid && issue_ready`.
- Per-register next state, in priority order:
  - `rst` or `flush`: count ← 0.
  - Otherwise, with inc = (accept && issue_wr && issue_dest == i) and dec = (wb_load && wb_dest == i && count[i] != 0):
    - inc && dec: unchanged.
    - inc only: +1.
    - dec only: −1.
- Index 0 is ignored for both inc and dec. Issue with dest 0 never blocks and never counts.
- Underflow: `wb_load && wb_dest != 0 && count[wb_dest] == 0 && !inc(wb_dest)` sets `err_underflow` at the next edge. The count stays 0.
  - Suppressed while `flush` is high.
  - Cleared only by `rst`.
- Counts never wrap. Saturation is prevented by `hz_d`.

## Timing
- Reset values: all counts 0, `busy_vec` = 0, `err_underflow` = 0. `issue_ready` is then 1 unless `flush` is high.
- `rst` mid-operation discards all pending state at the next edge. `rst` wins over `flush`, issue, and writeback.
- Counter updates take effect at the posedge after the accept or writeback cycle.
- A destination issued in cycle t shows in `busy_vec` from cycle t+1.
- A dependent instruction is ready:
  - in the cycle its producer's `wb_load` is asserted, through the bypass; or
  - any later cycle.
- The flush cycle forces `issue_ready` = 0. All counts are 0 from the next cycle.
- `issue_ready` has a combinational path from `wb_load`/`wb_dest`. `busy_vec` is state-only.
- No internal pipelining. Throughput is one issue per cycle.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs. Expect `busy_vec` = 0, `err_underflow` = 0, and `issue_ready` = 1 with all use/wr low.
- RAW stall and bypass release:
  - Issue wr x5 at t0.
  - At t1, issue use_a src_a=5. Expect `issue_ready` = 0 while x5 is pending.
  - Drive wb_load, wb_dest=5 at t3. Expect `issue_ready` = 1 at t3 and `busy_vec[5]` = 0 at t4.
- Simultaneous events:
  - count[7]=1; same cycle, issue wr x7 and wb x7. Expect count[7] stays 1 and `busy_vec[7]` = 1.
  - A source read of x7 in that cycle is not bypassed while count is 2.
- Saturation, CNT_W=2:
  - Issue 3 writes to x9. Expect the fourth stalls (`issue_ready` = 0).
  - With wb x9 in the same cycle, the fourth issues and count stays 3.
- x0 and flush:
  - Issue wr x0 and use x0. Expect never stalled and `busy_vec` = 0.
  - With x1–x4 pending, assert `flush` alongside issue_valid. Expect `issue_ready` = 0 that cycle, no count change from the issue, and `busy_vec` = 0 next cycle.
- Underflow: wb_load with wb_dest=12 while count[12]=0. Expect `err_underflow` = 1 the next cycle and held until `rst`, with count[12] remaining 0.
